gpio_input_conditioner: RTL and testbench

//  Per-pin input front-end between GPIO pads and the GPIO controller's gpio_io_i input.
//  - Synchronises asynchronous pad inputs into aclk.
//  - Debounces each pin; debounce can be bypassed per pin.
//  - Detects rising/falling edges and latches sticky interrupt status; irq is the OR of all status bits.

---
 rtl/gpio_input_conditioner.sv | 145 ++++++++++++++
 tb/tb_gpio_input_conditioner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
//   Per-pin input front-end between GPIO pads and the GPIO controller.
//   Each pin is synchronised into aclk, optionally debounced, and then
//   edge-detected.  Edges that are enabled set sticky interrupt status bits.
//
// Ports
//   aclk        clock
//   aresetn     synchronous active-low reset
//   pad_i       raw asynchronous pad levels
//   db_en       per pin: 1 = debounce, 0 = take the synchroniser output directly
//   rise_en     per pin: an accepted rising edge sets irq_status
//   fall_en     per pin: an accepted falling edge sets irq_status
//   irq_clear   per pin: write-1-to-clear pulse for irq_status
//   gpio_io_i   conditioned (stable) pin level
//   rise_pulse  one-cycle pulse on an accepted 0->1 of gpio_io_i
//   fall_pulse  one-cycle pulse on an accepted 1->0 of gpio_io_i
//   irq_status  sticky edge status
//   irq         OR of all irq_status bits
module gpio_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] db_en,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] gpio_io_i,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value on which the change is accepted (the Nth stable cycle).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] y_s;
    logic [WIDTH-1:0] level_r;
    logic [WIDTH-1:0] level_next_s;
    logic [WIDTH-1:0] level_d_r;
    logic [CNT_W-1:0] cnt_r      [WIDTH];
    logic [CNT_W-1:0] cnt_next_s [WIDTH];
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] irq_status_r;
    logic [WIDTH-1:0] irq_status_next_s;

    // Synchroniser flop chain; the last stage is the synchronised level y.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= ALL_ZERO;
            end
        end else begin
            sync_r[0] <= pad_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign y_s = sync_r[SYNC_STAGES-1];

    // Per-pin debounce: count consecutive cycles where y differs from the
    // stable level; accept on the Nth.  Bypass copies y and parks the counter
    // at zero, so re-enabling debounce always starts a fresh count.
    always_comb begin
        level_next_s = level_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next_s[i] = cnt_r[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (!db_en[i]) begin
                level_next_s[i] = y_s[i];
                cnt_next_s[i]   = CNT_ZERO;
            end else if (y_s[i] == level_r[i]) begin
                cnt_next_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                level_next_s[i] = y_s[i];
                cnt_next_s[i]   = CNT_ZERO;
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounce counters.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    // Stable level and its one-cycle delayed copy used for edge detection.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            level_r   <= ALL_ZERO;
            level_d_r <= ALL_ZERO;
        end else begin
            level_r   <= level_next_s;
            level_d_r <= level_r;
        end
    end

    assign rise_s = level_r & ~level_d_r;
    assign fall_s = ~level_r & level_d_r;
    assign set_s  = (rise_s & rise_en) | (fall_s & fall_en);

    // Set has priority over clear so an edge coinciding with a clear survives.
    always_comb begin
        irq_status_next_s = set_s | (irq_status_r & ~irq_clear);
    end

    // Sticky interrupt status register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            irq_status_r <= ALL_ZERO;
        end else begin
            irq_status_r <= irq_status_next_s;
        end
    end

    assign gpio_io_i  = level_r;
    assign rise_pulse = rise_s;
    assign fall_pulse = fall_s;
    assign irq_status = irq_status_r;
    assign irq        = |irq_status_r;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner (WIDTH=8, SYNC_STAGES=2, N=4).
// A driver applies inputs on the falling edge and, after each rising edge,
// advances a behavioural model and queues the expected outputs.  A monitor
// samples the DUT 1 time unit after each rising edge and compares.
module tb_gpio_input_conditioner;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int N    = 4;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [W-1:0] pad_i, db_en, rise_en, fall_en, irq_clear;
    logic [W-1:0] gpio_io_i, rise_pulse, fall_pulse, irq_status;
    logic         irq;

    gpio_input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(N)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .pad_i(pad_i), .db_en(db_en),
        .rise_en(rise_en), .fall_en(fall_en), .irq_clear(irq_clear),
        .gpio_io_i(gpio_io_i), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .irq_status(irq_status), .irq(irq)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int           idx;
        logic [W-1:0] gpio;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] irqs;
        logic         irq;
    } exp_t;

    typedef struct {
        int           idx;
        int           kind;   // 0 gpio, 1 rise, 2 fall, 3 irq_status, 4 irq
        logic [W-1:0] val;
    } dir_t;

    typedef struct {
        logic [W-1:0] en;
        logic [W-1:0] y;
    } hist_t;

    exp_t  sb_q[$];
    dir_t  dir_q[$];

    int checks   = 0;
    int failures = 0;
    int drv_cyc  = 0;

    // Staged inputs, applied at the next falling edge.
    logic         t_rstn;
    logic [W-1:0] t_pad, t_db, t_re, t_fe, t_clr;

    // Model state: pad delay line, window of recent debounce samples, levels, status.
    logic [W-1:0] dly_q[$];
    hist_t        hist[$];
    logic [W-1:0] m_s, m_sd, m_irq;

    task automatic model_reset();
        dly_q.delete();
        for (int k = 0; k < SYNC; k++) dly_q.push_back(8'h00);
        hist.delete();
        m_s   = 8'h00;
        m_sd  = 8'h00;
        m_irq = 8'h00;
    endtask

    // One clock edge of the reference: a change on a debounced pin is taken
    // when the last N samples were all debounced and all opposite to the level.
    task automatic model_edge();
        logic [W-1:0] y, rp, fp, new_s;
        hist_t        h;
        bit           ok;
        exp_t         e;
        if (!aresetn) begin
            model_reset();
        end else begin
            y  = dly_q[0];
            rp = m_s & ~m_sd;
            fp = ~m_s & m_sd;
            m_irq = (rp & rise_en) | (fp & fall_en) | (m_irq & ~irq_clear);
            void'(dly_q.pop_front());
            dly_q.push_back(pad_i);
            h.en = db_en;
            h.y  = y;
            hist.push_back(h);
            if (hist.size() > N) void'(hist.pop_front());
            new_s = m_s;
            for (int i = 0; i < W; i++) begin
                if (!db_en[i]) begin
                    new_s[i] = y[i];
                end else if (hist.size() == N) begin
                    ok = 1'b1;
                    foreach (hist[j]) begin
                        if (!hist[j].en[i] || hist[j].y[i] == m_s[i]) ok = 1'b0;
                    end
                    if (ok) new_s[i] = y[i];
                end
            end
            m_sd = m_s;
            m_s  = new_s;
        end
        drv_cyc++;
        e.idx  = drv_cyc;
        e.gpio = m_s;
        e.rise = m_s & ~m_sd;
        e.fall = ~m_s & m_sd;
        e.irqs = m_irq;
        e.irq  = |m_irq;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(negedge aclk);
        aresetn   = t_rstn;
        pad_i     = t_pad;
        db_en     = t_db;
        rise_en   = t_re;
        fall_en   = t_fe;
        irq_clear = t_clr;
        @(posedge aclk);
        model_edge();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Directed expectation checked by the monitor for the most recent edge.
    task automatic expect_dir(input int kind, input logic [W-1:0] val);
        dir_t d;
        d.idx  = drv_cyc;
        d.kind = kind;
        d.val  = val;
        dir_q.push_back(d);
    endtask

    // Monitor: pop and compare one expected set of outputs per clock.
    always @(posedge aclk) begin
        exp_t         e;
        dir_t         d;
        logic [W-1:0] act;
        string        nm;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (gpio_io_i !== e.gpio || rise_pulse !== e.rise || fall_pulse !== e.fall ||
                irq_status !== e.irqs || irq !== e.irq) begin
                failures++;
                $display("FAIL sb cyc=%0d actual gpio=%h rise=%h fall=%h irqs=%h irq=%b required gpio=%h rise=%h fall=%h irqs=%h irq=%b",
                         e.idx, gpio_io_i, rise_pulse, fall_pulse, irq_status, irq,
                         e.gpio, e.rise, e.fall, e.irqs, e.irq);
            end
            while (dir_q.size() > 0 && dir_q[0].idx == e.idx) begin
                d = dir_q.pop_front();
                case (d.kind)
                    0:       begin act = gpio_io_i;      nm = "gpio";       end
                    1:       begin act = rise_pulse;     nm = "rise";       end
                    2:       begin act = fall_pulse;     nm = "fall";       end
                    3:       begin act = irq_status;     nm = "irq_status"; end
                    default: begin act = {7'd0, irq};    nm = "irq";        end
                endcase
                checks++;
                if (act !== d.val) begin
                    failures++;
                    $display("FAIL dir_%s cyc=%0d actual=%h required=%h", nm, e.idx, act, d.val);
                end
            end
        end
    end

    initial begin
        model_reset();
        t_rstn = 1'b0; t_pad = 8'hFF; t_db = 8'hFF; t_re = 8'h00; t_fe = 8'h00; t_clr = 8'h00;
        aresetn = t_rstn; pad_i = t_pad; db_en = t_db;
        rise_en = t_re; fall_en = t_fe; irq_clear = t_clr;

        // Reset with pads high, then acceptance 2+4 cycles after release.
        steps(3);
        expect_dir(0, 8'h00); expect_dir(1, 8'h00); expect_dir(3, 8'h00);
        t_rstn = 1'b1;
        steps(5);
        expect_dir(0, 8'h00);
        step();
        expect_dir(0, 8'hFF); expect_dir(1, 8'hFF);
        step();
        expect_dir(1, 8'h00); expect_dir(4, 8'h00);

        // Bounce rejection on pin 0.
        t_pad = 8'h00;
        steps(8);
        t_db = 8'h01;
        t_pad = 8'h01; steps(3);
        t_pad = 8'h00; step();
        t_pad = 8'h01;
        steps(5);
        expect_dir(0, 8'h00);
        step();
        expect_dir(0, 8'h01); expect_dir(1, 8'h01);
        steps(4);

        // Bypass single-cycle pulse.
        t_db = 8'h00; t_pad = 8'h00;
        steps(4);
        t_pad = 8'hA5; step();
        t_pad = 8'h00; step(); step();
        expect_dir(0, 8'hA5); expect_dir(1, 8'hA5);
        step();
        expect_dir(0, 8'h00); expect_dir(2, 8'hA5); expect_dir(1, 8'h00);
        steps(2);

        // Interrupt status from enabled edges, then clear.
        t_re = 8'h0F; t_fe = 8'hF0;
        t_pad = 8'hFF; steps(5);
        expect_dir(3, 8'h0F);
        t_pad = 8'h00; steps(5);
        expect_dir(3, 8'hFF); expect_dir(4, 8'h01);
        t_clr = 8'h0F; step();
        expect_dir(3, 8'hF0);
        t_clr = 8'h00; step();
        expect_dir(3, 8'hF0);

        // Set wins over a simultaneous clear on pin 2.
        t_pad = 8'h04; steps(3);
        t_clr = 8'h04; step();
        expect_dir(3, 8'hF4);
        step();
        expect_dir(3, 8'hF0);
        t_clr = 8'h00; t_pad = 8'h00; steps(4);
        t_clr = 8'hFF; step();
        t_clr = 8'h00; t_re = 8'h00; t_fe = 8'h00; step();
        expect_dir(4, 8'h00);

        // Reset in the middle of a debounce count on pin 1.
        t_db = 8'hFF; t_pad = 8'h02;
        steps(4);
        t_rstn = 1'b0; steps(2);
        expect_dir(0, 8'h00);
        t_rstn = 1'b1; steps(5);
        expect_dir(0, 8'h00);
        step();
        expect_dir(0, 8'h02); expect_dir(1, 8'h02);

        // Randomised phase against the reference model.
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 4) == 0) t_pad[b] = ~t_pad[b];
            end
            if ($urandom_range(0, 39) == 0) t_db = 8'($urandom);
            if ($urandom_range(0, 29) == 0) t_re = 8'($urandom);
            if ($urandom_range(0, 29) == 0) t_fe = 8'($urandom);
            t_clr  = 8'($urandom & $urandom & $urandom);
            t_rstn = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
            step();
        end
        t_rstn = 1'b1; t_clr = 8'h00;
        steps(3);
        @(negedge aclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
